lcd_refresh_ctrl: RTL and testbench



---
 rtl/lcd_pkg.sv | 35 +++
 rtl/lcd_tick_gen.sv | 29 ++
 rtl/lcd_refresh_ctrl.sv | 174 +++++++++++++++++
 tb/tb_lcd_refresh_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780-style LCD refresh sequencer:
// FSM state encoding, panel command bytes and sequence lengths.
package lcd_pkg;

  typedef logic [2:0] lcd_state_t;

  localparam lcd_state_t StPwrup   = 3'd0;
  localparam lcd_state_t StInit    = 3'd1;
  localparam lcd_state_t StClrwait = 3'd2;
  localparam lcd_state_t StRedraw  = 3'd3;
  localparam lcd_state_t StIdle    = 3'd4;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;

  localparam logic [7:0] LINE1_ADDR = 8'h80;
  localparam logic [7:0] LINE2_ADDR = 8'hC0;

  localparam int unsigned InitWrites   = 4;
  localparam int unsigned RedrawWrites = 34;
  // Redraw step that carries the line-2 address command.
  localparam int unsigned Line2Step    = 17;

  function automatic logic [7:0] init_cmd(input logic [1:0] n);
    case (n)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_ENTRY;
      default: return CMD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_tick_gen.sv
// Free-running divider: tick is high for one clk every CLK_DIV cycles,
// when the counter sits at CLK_DIV-1.
module lcd_tick_gen #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CntW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// HD44780 16x2 sequencer: power-up wait, init commands, then full redraws of
// both lines from the string ROM, with 2-tick E strobes per write.
module lcd_refresh_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 50000,
  parameter int unsigned PWRUP_STEPS = 20,
  parameter int unsigned CLEAR_STEPS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       refresh_req,
  input  logic [7:0] char_in,
  output logic [4:0] index,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);

  localparam int unsigned MaxA     = (PWRUP_STEPS > RedrawWrites) ? PWRUP_STEPS : RedrawWrites;
  localparam int unsigned MaxSteps = (CLEAR_STEPS > MaxA) ? CLEAR_STEPS : MaxA;
  localparam int unsigned StepW    = $clog2(MaxSteps + 1);

  logic             tick;
  lcd_state_t       state_q, state_d;
  logic             phase_q, phase_d;  // 1: E is high, next tick is the e-fall
  logic [StepW-1:0] step_q, step_d;
  logic             pend_q, pend_d;
  logic [4:0]       index_q, index_d;
  logic             e_q, e_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;

  logic             wr_rs;
  logic [7:0]       wr_data;
  logic             wr_last;

  lcd_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Decode the write belonging to the current step.
  always_comb begin
    wr_rs   = 1'b0;
    wr_data = 8'h00;
    wr_last = 1'b0;
    if (state_q == StInit) begin
      wr_data = init_cmd(step_q[1:0]);
      wr_last = (step_q == StepW'(InitWrites - 1));
    end else begin
      wr_last = (step_q == StepW'(RedrawWrites - 1));
      if (step_q == '0) begin
        wr_data = LINE1_ADDR;
      end else if (step_q == StepW'(Line2Step)) begin
        wr_data = LINE2_ADDR;
      end else begin
        wr_rs   = 1'b1;
        wr_data = char_in;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    step_d  = step_q;
    pend_d  = pend_q;
    index_d = index_q;
    e_d     = e_q;
    rs_d    = rs_q;
    data_d  = data_q;

    if (refresh_req && (state_q != StIdle)) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      StPwrup: begin
        if (tick) begin
          if (step_q == StepW'(PWRUP_STEPS - 1)) begin
            step_d  = '0;
            state_d = StInit;
          end else begin
            step_d = step_q + StepW'(1);
          end
        end
      end
      StClrwait: begin
        if (tick) begin
          if (step_q == StepW'(CLEAR_STEPS - 1)) begin
            step_d  = '0;
            state_d = StRedraw;
          end else begin
            step_d = step_q + StepW'(1);
          end
        end
      end
      StInit, StRedraw: begin
        if (tick) begin
          if (!phase_q) begin
            e_d     = 1'b1;
            rs_d    = wr_rs;
            data_d  = wr_data;
            phase_d = 1'b1;
          end else begin
            e_d     = 1'b0;
            phase_d = 1'b0;
            if (wr_rs) begin
              index_d = index_q + 5'd1;
            end
            if (!wr_last) begin
              step_d = step_q + StepW'(1);
            end else begin
              step_d = '0;
              if (state_q == StInit) begin
                state_d = (CLEAR_STEPS == 0) ? StRedraw : StClrwait;
              end else if (pend_q || refresh_req) begin
                // Chain straight into the next redraw so busy never drops.
                state_d = StRedraw;
                pend_d  = 1'b0;
              end else begin
                state_d = StIdle;
              end
            end
          end
        end
      end
      StIdle: begin
        if (refresh_req) begin
          state_d = StRedraw;
        end
      end
      default: begin
        state_d = StPwrup;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StPwrup;
      phase_q <= 1'b0;
      step_q  <= '0;
      pend_q  <= 1'b0;
      index_q <= 5'd0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      pend_q  <= pend_d;
      index_q <= index_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  assign index    = index_q;
  assign busy     = (state_q != StIdle) || pend_q;
  assign lcd_e    = e_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_data = data_q;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Bench for lcd_refresh_ctrl: a tick-driven queue-of-actions model checked every
// cycle, plus directed scenarios with hand-computed timing and write contents.
module tb_lcd_refresh_ctrl;

  localparam int unsigned ClkDiv = 4;
  localparam int unsigned Pwr    = 3;
  localparam int unsigned Clr    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       refresh_req = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic [4:0] index;
  logic       busy, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  int checks = 0;
  int errors = 0;

  lcd_refresh_ctrl #(
    .CLK_DIV    (ClkDiv),
    .PWRUP_STEPS(Pwr),
    .CLEAR_STEPS(Clr)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .refresh_req(refresh_req),
    .char_in    (char_in),
    .index      (index),
    .busy       (busy),
    .lcd_e      (lcd_e),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_data   (lcd_data)
  );

  always #5 clk = ~clk;

  // String ROM: 0x40 + index, one clk late.
  always @(posedge clk) char_in <= 8'h40 + {3'b000, index};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [1:0] kind;
    logic       rs;
    logic       rom;
    logic [7:0] data;
    logic       last;
  } act_t;
  localparam logic [1:0] KWait = 2'd0, KRise = 2'd1, KFall = 2'd2;

  act_t       q[$];
  act_t       m_act;
  int         tcnt;
  logic       m_tick;
  logic       m_e = 1'b0, m_rs = 1'b0, m_pend = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic [4:0] m_idx = 5'd0;

  task automatic push_write(input logic rs, input logic rom, input logic [7:0] d,
                            input logic last);
    q.push_back({KRise, rs, rom, d, 1'b0});
    q.push_back({KFall, rs, rom, d, last});
  endtask

  task automatic push_redraw();
    push_write(1'b0, 1'b0, 8'h80, 1'b0);
    for (int i = 0; i < 16; i++) push_write(1'b1, 1'b1, 8'h00, 1'b0);
    push_write(1'b0, 1'b0, 8'hC0, 1'b0);
    for (int i = 16; i < 32; i++) push_write(1'b1, 1'b1, 8'h00, i == 31);
  endtask

  task automatic push_boot();
    for (int i = 0; i < Pwr; i++) q.push_back({KWait, 1'b0, 1'b0, 8'h00, 1'b0});
    push_write(1'b0, 1'b0, 8'h38, 1'b0);
    push_write(1'b0, 1'b0, 8'h0C, 1'b0);
    push_write(1'b0, 1'b0, 8'h06, 1'b0);
    push_write(1'b0, 1'b0, 8'h01, 1'b0);
    for (int i = 0; i < Clr; i++) q.push_back({KWait, 1'b0, 1'b0, 8'h00, 1'b0});
    push_redraw();
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt = 0; m_e = 1'b0; m_rs = 1'b0; m_data = 8'h00; m_idx = 5'd0; m_pend = 1'b0;
      q.delete();
      push_boot();
    end else begin
      m_tick = (tcnt == ClkDiv - 1);
      tcnt = (tcnt + 1) % ClkDiv;
      if (q.size() == 0) begin
        if (refresh_req) push_redraw();
      end else if (m_tick) begin
        m_act = q.pop_front();
        if (m_act.kind == KRise) begin
          m_e = 1'b1;
          m_rs = m_act.rs;
          m_data = m_act.rom ? 8'h40 + {3'b000, m_idx} : m_act.data;
        end else if (m_act.kind == KFall) begin
          m_e = 1'b0;
          if (m_act.rom) m_idx = m_idx + 5'd1;
        end
        if (m_act.last) begin
          if (m_pend || refresh_req) push_redraw();
          m_pend = 1'b0;
        end else if (refresh_req) begin
          m_pend = 1'b1;
        end
      end else if (refresh_req) begin
        m_pend = 1'b1;
      end
    end
  end

  // Per-cycle compare: {e, rs, rw, data, index, busy}.
  always @(negedge clk) begin
    if (!rst) begin
      check("model_outputs", {15'd0, lcd_e, lcd_rs, lcd_rw, lcd_data, index, busy},
            {15'd0, m_e, m_rs, 1'b0, m_data, m_idx, (q.size() != 0) || m_pend});
    end
  end

  // ---------------- write capture and strobe timing ----------------
  logic [8:0] cap[$];
  int         rise_t[$];
  int         cap_cyc = 0, hi_len = 0, lo_len = 0;
  logic       prev_e = 1'b0, seen_fall = 1'b0;

  always @(negedge clk) begin
    cap_cyc++;
    if (rst) begin
      prev_e = 1'b0; hi_len = 0; lo_len = 0; seen_fall = 1'b0;
    end else begin
      if (lcd_e && !prev_e) begin
        cap.push_back({lcd_rs, lcd_data});
        rise_t.push_back(cap_cyc);
        if (seen_fall) check("e_low_time_at_least_clkdiv", lo_len >= ClkDiv, 1);
        hi_len = 0;
      end
      if (!lcd_e && prev_e) begin
        check("e_high_time", hi_len, ClkDiv);
        seen_fall = 1'b1;
        lo_len = 0;
      end
      if (lcd_e) hi_len++;
      else lo_len++;
      prev_e = lcd_e;
    end
  end

  // ---------------- directed scenarios ----------------
  function automatic logic [8:0] boot_write(input int i);
    logic [7:0] init_tab [4];
    init_tab = '{8'h38, 8'h0C, 8'h06, 8'h01};
    if (i < 4) return {1'b0, init_tab[i]};
    if (i == 4) return {1'b0, 8'h80};
    if (i < 21) return {1'b1, 8'h40 + 8'(i - 5)};
    if (i == 21) return {1'b0, 8'hC0};
    return {1'b1, 8'h50 + 8'(i - 22)};
  endfunction

  // Called right after rst is released on a negedge.
  task automatic boot_check();
    int n = 0;
    int m = 0;
    while (!lcd_e && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("boot_first_rise_cycle", n, 16);
    check("boot_first_cmd", {lcd_rs, lcd_data}, {1'b0, 8'h38});
    while (busy && m < 2000) begin
      @(negedge clk);
      m++;
    end
    check("boot_busy_fall", busy, 0);
    check("boot_write_count", cap.size(), 38);
    if (cap.size() == 38) begin
      for (int i = 0; i < 38; i++) check("boot_write_content", cap[i], boot_write(i));
      check("init_cmd_spacing", rise_t[1] - rise_t[0], 2 * ClkDiv);
      check("clear_to_line1_gap", rise_t[4] - rise_t[3], (2 + Clr) * ClkDiv);
    end
    check("index_wrapped", index, 0);
  endtask

  task automatic start_req(output int lat);
    refresh_req = 1'b1;
    lat = 0;
    while (!lcd_e && lat < 50) begin
      @(negedge clk);
      lat++;
      refresh_req = 1'b0;
    end
    refresh_req = 1'b0;
  endtask

  task automatic run_until_idle(input int pa, input int pb, input int pc, output int m);
    m = 0;
    while (busy && m < 3000) begin
      @(negedge clk);
      m++;
      refresh_req = (m == pa) || (m == pb) || (m == pc);
    end
    refresh_req = 1'b0;
  endtask

  initial begin
    int lat;
    int m;
    int n;

    repeat (3) @(negedge clk);
    check("reset_lcd_e", lcd_e, 0);
    check("reset_lcd_rs", lcd_rs, 0);
    check("reset_lcd_rw", lcd_rw, 0);
    check("reset_lcd_data", lcd_data, 0);
    check("reset_index", index, 0);
    check("reset_busy", busy, 1);

    cap.delete(); rise_t.delete();
    rst = 1'b0;
    boot_check();

    // Idle request: one redraw, 68 ticks.
    repeat (7) @(negedge clk);
    cap.delete(); rise_t.delete();
    start_req(lat);
    check("req_to_e_rise_max", (lat >= 1) && (lat <= ClkDiv + 1), 1);
    run_until_idle(0, 0, 0, m);
    check("redraw_rise_to_busy_fall", m, 67 * ClkDiv);
    check("redraw_write_count", cap.size(), 34);
    if (cap.size() == 34) begin
      check("redraw_first", cap[0], {1'b0, 8'h80});
      check("redraw_line2", cap[17], {1'b0, 8'hC0});
      check("redraw_last", cap[33], {1'b1, 8'h5F});
    end

    // Three requests while busy: exactly one extra redraw, no busy gap.
    repeat (5) @(negedge clk);
    cap.delete(); rise_t.delete();
    start_req(lat);
    run_until_idle(20, 60, 100, m);
    check("pending_two_redraws_span", m, 135 * ClkDiv);
    check("pending_write_count", cap.size(), 68);
    if (cap.size() == 68) check("pending_second_start", cap[34], {1'b0, 8'h80});
    repeat (12) @(negedge clk);
    check("pending_no_third_redraw", busy, 0);

    // Request coincident with the final e-fall tick.
    repeat (6) @(negedge clk);
    cap.delete(); rise_t.delete();
    start_req(lat);
    run_until_idle(67 * ClkDiv - 1, 0, 0, m);
    check("boundary_req_span", m, 135 * ClkDiv);
    check("boundary_write_count", cap.size(), 68);
    check("lcd_rw_low", lcd_rw, 0);

    // Reset while E is high mid-redraw.
    repeat (3) @(negedge clk);
    start_req(lat);
    n = 0;
    while (!(lcd_e && index >= 5'd4) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("midreset_reached_strobe", lcd_e, 1);
    #2 rst = 1'b1;
    #1;
    check("midreset_lcd_e", lcd_e, 0);
    check("midreset_lcd_data", lcd_data, 0);
    check("midreset_index", index, 0);
    check("midreset_busy", busy, 1);
    @(negedge clk);
    @(negedge clk);
    cap.delete(); rise_t.delete();
    rst = 1'b0;
    boot_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
